// File: rtl/ball_motion_logic.sv
// Ball motion: latches shot velocity in IDLE, then integrates fixed-point position per frame
// with walls and friction until stopped. Optional macro BALL_WALL_BOUNCE_EN: walls reflect velocity instead of zeroing it.

module ball_axis #(
  parameter int MIN_P = 32,
  parameter int MAX_P = 592,
  parameter int SHIFT = 6
) (
  input  logic signed [16:0] pos,
  input  logic signed [10:0] vel,
  input  logic               frictionTick,
  output logic signed [16:0] posNext,
  output logic signed [10:0] velNext
);
  localparam logic signed [17:0] LO = 18'(MIN_P <<< SHIFT);
  localparam logic signed [17:0] HI = 18'(MAX_P <<< SHIFT);

  logic signed [17:0] sum;
  logic signed [10:0] velWall;
  logic               wallHit;

  always_comb begin
    sum     = 18'(pos) + 18'(vel);
    wallHit = 1'b0;
    posNext = sum[16:0];
    if (sum < LO) begin
      posNext = LO[16:0];
      wallHit = 1'b1;
    end else if (sum > HI) begin
      posNext = HI[16:0];
      wallHit = 1'b1;
    end
`ifdef BALL_WALL_BOUNCE_EN
    velWall = wallHit ? -vel : vel;
`else
    velWall = wallHit ? '0 : vel;
`endif
    // friction acts on the post-wall velocity, always toward zero
    velNext = velWall;
    if (frictionTick && velWall != '0)
      velNext = (velWall > 0) ? velWall - 11'sd1 : velWall + 11'sd1;
  end
endmodule

module ball_motion_logic #(
  parameter int INIT_X            = 320,
  parameter int INIT_Y            = 240,
  parameter int MIN_X             = 32,
  parameter int MAX_X             = 592,
  parameter int MIN_Y             = 32,
  parameter int MAX_Y             = 432,
  parameter int FIXED_POINT_SHIFT = 6,
  parameter int FRICTION_PERIOD   = 4,
  parameter int VELOCITY_LIMIT    = 200
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               velocityWriteEnable,
  input  logic signed [10:0] newVelocityX,
  input  logic signed [10:0] newVelocityY,
  input  logic               respawnBall,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic signed [10:0] velocityX,
  output logic signed [10:0] velocityY,
  output logic               ballMoving,
  output logic               ballStopped
);
  localparam int NUM_AXES = 2;
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [16:0] INIT_PX = 17'(INIT_X <<< FIXED_POINT_SHIFT);
  localparam logic [16:0] INIT_PY = 17'(INIT_Y <<< FIXED_POINT_SHIFT);
  localparam logic signed [10:0] VLIM = 11'(VELOCITY_LIMIT);

  typedef enum logic {IDLE, MOVING} state_t;

  state_t state, stateNext;
  logic [NUM_AXES-1:0][16:0] posQ, posD, posAxis;
  logic [NUM_AXES-1:0][10:0] velQ, velD, velAxis;
  logic [CW-1:0] fricCnt, fricCntD;
  logic stoppedD, frictionTick;

  function automatic logic [10:0] sat(input logic signed [10:0] v);
    if (v > VLIM)       return VLIM;
    else if (v < -VLIM) return -VLIM;
    else                return v;
  endfunction

  assign frictionTick = (fricCnt == CW'(FRICTION_PERIOD - 1));

  for (genvar a = 0; a < NUM_AXES; a++) begin : gAxis
    ball_axis #(
      .MIN_P (a == 0 ? MIN_X : MIN_Y),
      .MAX_P (a == 0 ? MAX_X : MAX_Y),
      .SHIFT (FIXED_POINT_SHIFT)
    ) uAxis (
      .pos          (posQ[a]),
      .vel          (velQ[a]),
      .frictionTick (frictionTick),
      .posNext      (posAxis[a]),
      .velNext      (velAxis[a])
    );
  end

  always_comb begin
    stateNext = state;
    posD      = posQ;
    velD      = velQ;
    fricCntD  = fricCnt;
    stoppedD  = 1'b0;
    if (respawnBall) begin
      stateNext = IDLE;
      posD      = {INIT_PY, INIT_PX};
      velD      = '0;
      fricCntD  = '0;
    end else if (velocityWriteEnable && state == IDLE) begin
      // a coincident frame pulse is ignored here: IDLE never integrates
      velD[0]  = sat(newVelocityX);
      velD[1]  = sat(newVelocityY);
      fricCntD = '0;
      if (velD != '0) stateNext = MOVING;
    end else if (startOfFrame && state == MOVING) begin
      posD     = posAxis;
      velD     = velAxis;
      fricCntD = frictionTick ? '0 : fricCnt + 1'b1;
      if (velAxis == '0) begin
        stateNext = IDLE;
        stoppedD  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      posQ        <= {INIT_PY, INIT_PX};
      velQ        <= '0;
      fricCnt     <= '0;
      ballStopped <= 1'b0;
    end else begin
      state       <= stateNext;
      posQ        <= posD;
      velQ        <= velD;
      fricCnt     <= fricCntD;
      ballStopped <= stoppedD;
    end
  end

  logic signed [16:0] posXs, posYs;
  assign posXs = posQ[0];
  assign posYs = posQ[1];

  assign topLeftX   = 11'(posXs >>> FIXED_POINT_SHIFT);
  assign topLeftY   = 11'(posYs >>> FIXED_POINT_SHIFT);
  assign velocityX  = velQ[0];
  assign velocityY  = velQ[1];
  assign ballMoving = (state == MOVING);
endmodule

// File: tb/tb_ball_motion_logic.sv
// Directed bench for ball_motion_logic with a queue scoreboard; a second instance uses MAX_X=322 for wall tests.

module tb_ball_motion_logic;
  logic clk = 1'b0;
  logic resetN, startOfFrame, velocityWriteEnable, respawnBall;
  logic signed [10:0] newVelocityX, newVelocityY;
  logic signed [10:0] topLeftX, topLeftY, velocityX, velocityY;
  logic signed [10:0] wTopLeftX, wTopLeftY, wVelocityX, wVelocityY;
  logic ballMoving, ballStopped, wMoving, wStopped;

  always #5 clk = ~clk;

  ball_motion_logic dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .velocityWriteEnable(velocityWriteEnable),
    .newVelocityX(newVelocityX), .newVelocityY(newVelocityY),
    .respawnBall(respawnBall),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .velocityX(velocityX), .velocityY(velocityY),
    .ballMoving(ballMoving), .ballStopped(ballStopped)
  );

  ball_motion_logic #(.MAX_X(322)) dutW (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .velocityWriteEnable(velocityWriteEnable),
    .newVelocityX(newVelocityX), .newVelocityY(newVelocityY),
    .respawnBall(respawnBall),
    .topLeftX(wTopLeftX), .topLeftY(wTopLeftY),
    .velocityX(wVelocityX), .velocityY(wVelocityY),
    .ballMoving(wMoving), .ballStopped(wStopped)
  );

  typedef enum int {TLX, TLY, VX, VY, MV, ST, W_TLX, W_VX, W_MV, W_ST} sel_t;
  typedef struct { string tag; sel_t sel; integer exp; } item_t;
  item_t sb[$];
  int nVec = 0, nErr = 0;

  function automatic integer obs(sel_t s);
    case (s)
      TLX:   return topLeftX;
      TLY:   return topLeftY;
      VX:    return velocityX;
      VY:    return velocityY;
      MV:    return {31'd0, ballMoving};
      ST:    return {31'd0, ballStopped};
      W_TLX: return wTopLeftX;
      W_VX:  return wVelocityX;
      W_MV:  return {31'd0, wMoving};
      default: return {31'd0, wStopped};
    endcase
  endfunction

  task automatic pushExp(input string tag, input sel_t s, input integer v);
    item_t it;
    it.tag = tag; it.sel = s; it.exp = v;
    sb.push_back(it);
  endtask

  task automatic checkAll();
    item_t it;
    integer o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o = obs(it.sel);
      nVec++;
      assert (o === it.exp) else begin
        nErr++;
        $error("FAIL %s: got %0d expected %0d", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
  endtask

  task automatic writeVel(input int vx, input int vy);
    newVelocityX = 11'(vx); newVelocityY = 11'(vy);
    velocityWriteEnable = 1'b1; tick(); velocityWriteEnable = 1'b0;
  endtask

  task automatic respawn();
    respawnBall = 1'b1; tick(); respawnBall = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; velocityWriteEnable = 1'b0;
    respawnBall = 1'b0; newVelocityX = '0; newVelocityY = '0;
    repeat (3) tick();
    resetN = 1'b1; tick();

    // reset state
    pushExp("rst_tlx", TLX, 320); pushExp("rst_tly", TLY, 240);
    pushExp("rst_vx", VX, 0);     pushExp("rst_vy", VY, 0);
    pushExp("rst_mv", MV, 0);     pushExp("rst_st", ST, 0);
    pushExp("rst_wtlx", W_TLX, 320);
    checkAll();

    // zero write stays idle
    writeVel(0, 0);
    pushExp("zero_mv", MV, 0); checkAll();

    // straight shot, friction after 4th frame
    writeVel(64, 0);
    pushExp("shot_mv", MV, 1); pushExp("shot_vx", VX, 64); checkAll();
    for (int f = 1; f <= 4; f++) begin
      frame();
      pushExp("shot_mv_f", MV, 1);
      pushExp("shot_tlx_f", TLX, 320 + f);
      pushExp("shot_vx_f", VX, (f == 4) ? 63 : 64);
      checkAll();
      tick();
    end
    pushExp("shot_tly", TLY, 240); checkAll();
    respawn();
    pushExp("resp_tlx", TLX, 320); pushExp("resp_mv", MV, 0); checkAll();

    // friction stop
    writeVel(1, 0);
    for (int f = 1; f <= 3; f++) begin
      frame();
      pushExp("slow_vx", VX, 1); pushExp("slow_mv", MV, 1); pushExp("slow_st", ST, 0);
      checkAll();
      tick();
    end
    frame();
    pushExp("stop_vx", VX, 0); pushExp("stop_st", ST, 1);
    pushExp("stop_mv", MV, 0); pushExp("stop_tlx", TLX, 320);
    checkAll();
    tick();
    pushExp("stop_st_pulse", ST, 0); checkAll();

    // saturation and wall
    respawn();
    writeVel(300, 0);
    pushExp("sat_vx", VX, 200); pushExp("sat_wvx", W_VX, 200); checkAll();
    frame();
    pushExp("wall_tlx", W_TLX, 322); pushExp("free_tlx", TLX, 323);
`ifdef BALL_WALL_BOUNCE_EN
    pushExp("wall_vx", W_VX, -200); pushExp("wall_mv", W_MV, 1); pushExp("wall_st", W_ST, 0);
`else
    pushExp("wall_vx", W_VX, 0); pushExp("wall_mv", W_MV, 0); pushExp("wall_st", W_ST, 1);
`endif
    checkAll();
    respawn();
    writeVel(-300, 0);
    pushExp("satneg_vx", VX, -200); checkAll();
    respawn();

    // write while moving is ignored
    writeVel(50, -30);
    frame(); tick(); frame(); tick();
    writeVel(-100, 0);
    pushExp("ign_vx", VX, 50); pushExp("ign_vy", VY, -30); pushExp("ign_mv", MV, 1);
    pushExp("ign_tlx", TLX, 321); pushExp("ign_tly", TLY, 239);
    checkAll();

    // respawn beats a coincident frame
    respawnBall = 1'b1; startOfFrame = 1'b1; tick();
    respawnBall = 1'b0; startOfFrame = 1'b0;
    pushExp("rsof_tlx", TLX, 320); pushExp("rsof_tly", TLY, 240);
    pushExp("rsof_vx", VX, 0);     pushExp("rsof_vy", VY, 0);
    pushExp("rsof_mv", MV, 0);     pushExp("rsof_st", ST, 0);
    checkAll();
    tick();
    pushExp("rsof_st2", ST, 0); checkAll();

    // write coincident with frame latches only
    newVelocityX = 11'sd64; newVelocityY = '0;
    velocityWriteEnable = 1'b1; startOfFrame = 1'b1; tick();
    velocityWriteEnable = 1'b0; startOfFrame = 1'b0;
    pushExp("wsof_tlx", TLX, 320); pushExp("wsof_vx", VX, 64); pushExp("wsof_mv", MV, 1);
    checkAll();
    frame();
    pushExp("wsof_tlx2", TLX, 321); checkAll();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule

// File: doc/ball_motion_logic.md
Name: ball_motion_logic

Overview:
Consumer end of the shot-velocity write interface. Captures the shot velocity on a write strobe and integrates the ball's position once per frame in fixed point. Applies friction and wall handling until the ball stops. Reports position to the drawing logic, and reports a moving/stopped status that gates the aiming line.

Parameters:
INIT_X, 320, reset/respawn top-left X in pixels
INIT_Y, 240, reset/respawn top-left Y in pixels
MIN_X, 32, lowest legal top-left X in pixels
MAX_X, 592, highest legal top-left X in pixels
MIN_Y, 32, lowest legal top-left Y in pixels
MAX_Y, 432, highest legal top-left Y in pixels
FIXED_POINT_SHIFT, 6, fractional bits of position; 1 velocity LSB = 1/64 px per frame
FRICTION_PERIOD, 4, frames between friction decrements (>=1)
VELOCITY_LIMIT, 200, saturation magnitude applied to captured velocity

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
velocityWriteEnable  in  1  one-cycle write strobe from the aiming logic
newVelocityX  in  11 signed  shot velocity X; +X is right
newVelocityY  in  11 signed  shot velocity Y; +Y is down
respawnBall  in  1  synchronous request to return the ball to INIT position, stopped
topLeftX  out  11 signed  integer pixel X, equal to posX >>> FIXED_POINT_SHIFT
topLeftY  out  11 signed  integer pixel Y, equal to posY >>> FIXED_POINT_SHIFT
velocityX  out  11 signed  current velocity X
velocityY  out  11 signed  current velocity Y
ballMoving  out  1  high while in MOVING
ballStopped  out  1  one-cycle pulse when motion ends by friction

Behaviour:
- Reset values:
  - posX = INIT_X<<SHIFT, posY = INIT_Y<<SHIFT (17-bit signed internal registers).
  - velocities 0, friction counter 0, state IDLE.
  - ballMoving = 0, ballStopped = 0.
- States:
  - IDLE: ball at rest, write accepted.
  - MOVING: position integrates each frame, writes ignored.
- Priority within a cycle: respawnBall > write > frame update.
- respawnBall (any state):
  - position set to INIT, velocities 0, counter 0, state IDLE next cycle.
  - No ballStopped pulse.
- Write in IDLE:
  - Each component is saturated to ±VELOCITY_LIMIT and latched.
  - Friction counter cleared.
  - If either component is nonzero, go to MOVING next cycle; ballMoving rises 1 cycle after the strobe.
  - If both components are zero, stay IDLE.
  - A write coincident with startOfFrame latches velocity only; no integration on that frame.
- Write in MOVING: ignored.
- On startOfFrame in MOVING, computed in this order:
  1. next = pos + sign-extended velocity, per axis.
  2. Wall check per axis: if next < MIN<<SHIFT, pos = MIN<<SHIFT and the wall action applies. If next > MAX<<SHIFT, pos = MAX<<SHIFT and the wall action applies. Otherwise pos = next.
  3. Friction counter increments. When it equals FRICTION_PERIOD-1 it wraps to 0 and each nonzero velocity component moves 1 toward 0, applied after any reflection.
  4. If both velocities are 0 after step 3: state returns to IDLE, ballMoving falls, and ballStopped pulses exactly 1 cycle. Both take effect on the cycle after the startOfFrame pulse.
- Each frame update completes in one cycle, so outputs reflect the new frame one cycle after startOfFrame.
- Both axes hitting walls on the same frame are handled independently.
- Position never leaves [MIN, MAX] on either axis.
- velocityX and velocityY outputs always show the live registers.

Optional Feature:
Macro BALL_WALL_BOUNCE_EN.
- Defined: the wall action negates that axis's velocity (elastic bounce).
- Undefined: the wall action zeroes that axis's velocity (ball sticks to the cushion). If this makes both velocities 0, the stop rule in step 4 applies on the same frame.

Test Plan:
1. Reset, then release: topLeft = (320,240), velocities 0, ballMoving = 0, ballStopped = 0.
2. Write vx=64, vy=0 in IDLE, then 4 startOfFrame pulses:
   - topLeftX = 324, topLeftY = 240.
   - velocityX = 63 after the 4th frame.
   - ballMoving = 1 throughout.
3. Write vx=1, vy=0, FRICTION_PERIOD=4:
   - After the 4th frame, velocityX = 0.
   - ballStopped pulses for one cycle and ballMoving drops.
   - topLeftX stays 320 (posX = 20484).
4. Set MAX_X=322 and write vx=300:
   - Captured velocity saturates to 200.
   - After frame 1, topLeftX = 322.
   - velocityX = -200 with BALL_WALL_BOUNCE_EN defined; 0 without it (ballStopped pulses).
5. Write vx=50 and vy=-30, wait 2 frames, then write vx=-100 while MOVING: the write is ignored and velocity stays at (50,-30).
6. While MOVING, assert respawnBall together with startOfFrame:
   - Next cycle: topLeft = (320,240), velocities 0, state IDLE.
   - No ballStopped pulse.
